axis_bist_src: RTL and testbench

- AXI4-Stream master that generates built-in-self-test sample packets for the fir_top S_AXIS slave port.
- Drives NUM_OF_PACKETS packets of NUM_OF_SAMPLES beats each, with TLAST on the final beat of every packet.
- Supports four patterns: ramp, LFSR, impulse and constant.
- Software/bench starts a run with START and observes BUSY/DONE.

---
 rtl/axis_bist_src.sv | 160 ++++++++++++++++
 tb/tb_axis_bist_src.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/axis_bist_src.sv
// AXI4-Stream BIST source: NUM_OF_PACKETS packets of ramp/LFSR/impulse/constant samples.
// Optional inter-packet idle gap is compiled in with BIST_GAP_EN.
//
// state  | meaning
// IDLE   | waiting for START after reset
// RUN    | presenting beats, TVALID=1
// GAP    | idle cycles between packets (BIST_GAP_EN only)
// DONE   | run complete, DONE sticky until next START
module axis_bist_src #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_OF_SAMPLES = 500,
    parameter int NUM_OF_PACKETS = 1,
    parameter int GAP_CYCLES     = 3
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  START,
    input  logic [1:0]            MODE,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  BUSY,
    output logic                  DONE,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID
);

    localparam int BW = $clog2(NUM_OF_SAMPLES + 1);
    localparam int PW = $clog2(NUM_OF_PACKETS + 1);
    localparam int LW = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_OF_SAMPLES - 1);
    localparam logic [PW-1:0] LAST_PKT  = PW'(NUM_OF_PACKETS - 1);
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef BIST_GAP_EN
        , S_GAP = 2'd3
`endif
    } state_t;

    state_t                r_state, w_next;
    logic [BW-1:0]         r_beat;
    logic [PW-1:0]         r_pkt;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [15:0]           r_lfsr;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0] w_tdata_next;
    logic [DATA_WIDTH-1:0] w_tdata_first;
    logic [15:0]           w_seed16;
    logic [15:0]           w_lfsr_first;
    logic [15:0]           w_lfsr_next;
    logic                  w_start;
    logic                  w_fire;
    logic                  w_last;

    function automatic logic [15:0] to16(input logic [DATA_WIDTH-1:0] v);
        to16 = '0;
        for (int i = 0; i < LW; i++) to16[i] = v[i];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fit(input logic [15:0] v);
        fit = '0;
        for (int i = 0; i < LW; i++) fit[i] = v[i];
    endfunction

    assign M_AXIS_TVALID = (r_state == S_RUN);
    assign M_AXIS_TLAST  = M_AXIS_TVALID && w_last;
    assign M_AXIS_TDATA  = r_tdata;
    assign DONE          = (r_state == S_DONE);
`ifdef BIST_GAP_EN
    assign BUSY          = (r_state == S_RUN) || (r_state == S_GAP);
`else
    assign BUSY          = (r_state == S_RUN);
`endif

    assign w_start      = ((r_state == S_IDLE) || (r_state == S_DONE)) && START;
    assign w_fire       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_last       = (r_beat == LAST_BEAT);
    assign w_seed16     = to16(SEED);
    assign w_lfsr_first = (w_seed16 == 16'h0000) ? 16'h0001 : w_seed16;
    assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign w_tdata_first = (MODE == 2'd1) ? fit(w_lfsr_first) : SEED;

    // Data for the beat after the current transfer; impulse restarts each packet.
    always_comb begin
        w_tdata_next = r_tdata;
        case (r_mode)
            2'd0:    w_tdata_next = r_tdata + 1'b1;
            2'd1:    w_tdata_next = fit(w_lfsr_next);
            2'd2:    w_tdata_next = w_last ? r_seed : '0;
            default: w_tdata_next = r_seed;
        endcase
    end

`ifdef BIST_GAP_EN
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GW-1:0] r_gap;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_gap <= '0;
        end else if (w_fire && w_last) begin
            r_gap <= GW'(GAP_CYCLES - 1);
        end else if ((r_state == S_GAP) && (r_gap != '0)) begin
            r_gap <= r_gap - 1'b1;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (START) w_next = S_RUN;
            S_RUN: begin
                if (w_fire && w_last) begin
                    if (r_pkt == LAST_PKT) w_next = S_DONE;
`ifdef BIST_GAP_EN
                    else if (GAP_CYCLES > 0) w_next = S_GAP;
`endif
                end
            end
`ifdef BIST_GAP_EN
            S_GAP: if (r_gap == '0) w_next = S_RUN;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_pkt   <= '0;
            r_mode  <= 2'd0;
            r_seed  <= '0;
            r_lfsr  <= 16'h0000;
            r_tdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_beat  <= '0;
                r_pkt   <= '0;
                r_mode  <= MODE;
                r_seed  <= SEED;
                r_lfsr  <= w_lfsr_first;
                r_tdata <= w_tdata_first;
            end else if (w_fire) begin
                r_beat  <= w_last ? '0 : r_beat + 1'b1;
                if (w_last) r_pkt <= r_pkt + 1'b1;
                r_lfsr  <= w_lfsr_next;
                r_tdata <= w_tdata_next;
            end
        end
    end

endmodule

// File: tb/tb_axis_bist_src.sv
// Bench for axis_bist_src: a 500x1 instance and a 5x3 instance checked against a pattern model.
module tb_axis_bist_src;

    localparam int DW = 16;
`ifdef BIST_GAP_EN
    localparam int GAP_EXP = 3;
`else
    localparam int GAP_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start_a, start_b, tready, sel;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic          a_busy, a_done, a_last, a_valid, b_busy, b_done, b_last, b_valid;
    logic [DW-1:0] a_data, b_data;
    logic          o_busy, o_done, o_last, o_valid;
    logic [DW-1:0] o_data;

    axis_bist_src #(.DATA_WIDTH(DW), .NUM_OF_SAMPLES(500), .NUM_OF_PACKETS(1), .GAP_CYCLES(3)) u_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start_a), .MODE(mode), .SEED(seed),
        .BUSY(a_busy), .DONE(a_done), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(a_data),
        .M_AXIS_TLAST(a_last), .M_AXIS_TVALID(a_valid));

    axis_bist_src #(.DATA_WIDTH(DW), .NUM_OF_SAMPLES(5), .NUM_OF_PACKETS(3), .GAP_CYCLES(3)) u_b (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start_b), .MODE(mode), .SEED(seed),
        .BUSY(b_busy), .DONE(b_done), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(b_data),
        .M_AXIS_TLAST(b_last), .M_AXIS_TVALID(b_valid));

    always_comb begin
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_last  = sel ? b_last  : a_last;
        o_valid = sel ? b_valid : a_valid;
        o_data  = sel ? b_data  : a_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One run on the selected instance; abort_at >= 0 pulses reset when that beat is reached.
    task automatic run(input bit sel_b, input logic [1:0] m, input logic [DW-1:0] s,
                       input bit rnd, input int abort_at);
        int ns    = sel_b ? 5 : 500;
        int np    = sel_b ? 3 : 1;
        int total = ns * np;
        logic [DW-1:0] ed[$];
        bit            el[$];
        logic [15:0]   lf;
        int idx = 0, idle = 0, cyc = 0;

        lf = (s == 16'h0000) ? 16'h0001 : s;
        for (int n = 0; n < total; n++) begin
            case (m)
                2'd0:    ed.push_back(DW'(s + n));
                2'd1:    ed.push_back(lf);
                2'd2:    ed.push_back((n % ns == 0) ? s : '0);
                default: ed.push_back(s);
            endcase
            el.push_back((n % ns) == ns - 1);
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
        end

        sel = sel_b;
        @(negedge clk);
        mode = m;
        seed = s;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("first_valid", o_valid, 1);
        chk("busy_start", o_busy, 1);
        chk("done_clear", o_done, 0);

        while (idx < total && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            mode = 2'($urandom);
            seed = DW'($urandom);
            if (sel_b) start_b = 1'($urandom_range(0, 1));
            if (idx == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_valid", o_valid, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                chk("abort_data", o_data, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (!o_valid) idle++;
            else begin
                chk("data", o_data, ed[idx]);
                chk("last", o_last, el[idx]);
            end
            if (idx % ns != 0) chk("valid_mid_packet", o_valid, 1);
            chk("busy_run", o_busy, 1);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && tready) idx++;
        end
        if (idx < total) chk("timeout_beats", idx, total);

        @(negedge clk);
        start_b = 1'b0;
        chk("end_valid", o_valid, 0);
        chk("end_busy", o_busy, 0);
        chk("end_done", o_done, 1);
        chk("gap_cycles", idle, GAP_EXP * (np - 1));
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tready  = 1'b0;
        sel     = 1'b0;
        mode    = 2'd0;
        seed    = '0;
        #23;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_last", b_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", a_valid, 0);

        run(1'b0, 2'd0, 16'h0000, 1'b0, -1);
        run(1'b1, 2'd0, 16'hFFFE, 1'b0, -1);
        run(1'b1, 2'd1, 16'h0000, 1'b0, -1);
        run(1'b1, 2'd1, 16'h0000, 1'b1, -1);
        run(1'b1, 2'd2, 16'h0100, 1'b1, -1);
        run(1'b1, 2'd3, 16'hA5C3, 1'b1, -1);
        for (int k = 0; k < 8; k++)
            run(1'b1, 2'($urandom_range(0, 3)), DW'($urandom), 1'b1, -1);
        run(1'b0, 2'($urandom_range(0, 3)), DW'($urandom), 1'b1, -1);
        run(1'b0, 2'd0, 16'h1234, 1'b0, 200);
        run(1'b0, 2'd0, 16'h1234, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
